// File: rtl/tlul_host_arbiter.sv
// Minimal TL-UL channel types plus an N:1 host arbiter: round-robin on the A channel,
// in-order routing of D-channel responses through a FIFO of grant indices.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_arbiter #(
  parameter int NumHosts       = 4,
  parameter int MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
  output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
  output tlul_pkg::tl_h2d_t tl_d_o,
  input  tlul_pkg::tl_d2h_t tl_d_i,
  output logic              idle_o,
  output logic              err_rsp_o
);
  localparam int HostIdxW = $clog2(NumHosts);
  localparam int PtrW     = $clog2(MaxOutstanding);
  localparam int CntW     = PtrW + 1;

  logic [HostIdxW-1:0] rr_q, rr_d, gnt_q, gnt_d, gnt, head;
  logic                lock_q, lock_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [MaxOutstanding-1:0][HostIdxW-1:0] fifo_q, fifo_d;

  logic any_req, any_valid, full, empty, a_vld, d_rdy, push, pop;
  int   idx;

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // A held lock pins the grant so a stalled request's payload stays put.
  always_comb begin
    any_req   = 1'b0;
    any_valid = 1'b0;
    gnt       = rr_q;
    idx       = 0;
    for (int i = 0; i < NumHosts; i++) any_valid = any_valid | tl_h_i[i].a_valid;
    if (lock_q) begin
      gnt     = gnt_q;
      any_req = tl_h_i[gnt_q].a_valid;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= NumHosts) idx = idx - NumHosts;
        if (!any_req && tl_h_i[idx].a_valid) begin
          gnt     = HostIdxW'(idx);
          any_req = 1'b1;
        end
      end
    end
  end

  assign a_vld = any_req & ~full & rst_ni;
  assign push  = a_vld & tl_d_i.a_ready;
  assign d_rdy = empty ? 1'b1 : tl_h_i[head].d_ready;
  assign pop   = ~empty & tl_d_i.d_valid & d_rdy;

  always_comb begin
    tl_d_o         = tl_h_i[gnt];
    tl_d_o.a_valid = a_vld;
    tl_d_o.d_ready = d_rdy;
    for (int i = 0; i < NumHosts; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].d_valid = ~empty & (head == HostIdxW'(i)) & tl_d_i.d_valid & rst_ni;
      tl_h_o[i].a_ready = (gnt == HostIdxW'(i)) & tl_d_i.a_ready & ~full & rst_ni;
    end
  end

  // Responses with nothing outstanding are sunk so the device never stalls on them.
  assign err_rsp_o = empty & tl_d_i.d_valid & rst_ni;
  assign idle_o    = ~rst_ni | (empty & ~any_valid);

  always_comb begin
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    lock_d   = lock_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    fifo_d   = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      rr_d             = (gnt == HostIdxW'(NumHosts - 1)) ? '0 : gnt + 1'b1;
      lock_d           = 1'b0;
    end else if (a_vld) begin
      lock_d = 1'b1;
      gnt_d  = gnt;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      gnt_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      fifo_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fifo_q   <= fifo_d;
    end
  end
endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter: a queue-based reference model checked every cycle,
// plus literal checks on grant order, response routing, full blocking and reset.
module tb_tlul_host_arbiter;
  import tlul_pkg::*;
  localparam int N  = 4;
  localparam int MO = 4;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t h_req [N];
  tl_d2h_t h_rsp [N];
  tl_h2d_t d_req;
  tl_d2h_t d_rsp;
  logic    idle, err;

  logic        h_valid  [N];
  logic [31:0] h_addr   [N];
  logic        h_dready [N];
  logic        dev_ardy, dev_dvalid;
  logic [31:0] dev_data;
  int          req_cnt [N];
  int          seq     [N];

  int pass_cnt = 0, total_cnt = 0;
  int acc_log [$];
  int rx_host [$];
  logic [31:0] rx_data [$];
  int m_rr, m_lock;
  int m_q [$];

  tlul_host_arbiter #(.NumHosts(N), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_req), .tl_h_o(h_rsp),
    .tl_d_o(d_req), .tl_d_i(d_rsp), .idle_o(idle), .err_rsp_o(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      h_req[i]           = '0;
      h_req[i].a_valid   = h_valid[i];
      h_req[i].a_opcode  = 3'd4;
      h_req[i].a_size    = 2'd2;
      h_req[i].a_source  = 8'(i);
      h_req[i].a_address = h_addr[i];
      h_req[i].a_mask    = 4'hf;
      h_req[i].d_ready   = h_dready[i];
    end
    d_rsp          = '0;
    d_rsp.a_ready  = dev_ardy;
    d_rsp.d_valid  = dev_dvalid;
    d_rsp.d_opcode = 3'd1;
    d_rsp.d_data   = dev_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: an ordered list of who is owed a response, a round-robin start host,
  // and the host whose request is stalled at the device.
  always @(negedge clk) begin : cmp
    int  gnt, head;
    bit  any, full, empty, nv;
    if (!rst_n) begin
      m_q.delete();
      m_rr   = 0;
      m_lock = -1;
      chk("rst a_valid", 32'(d_req.a_valid), 0);
      chk("rst idle", 32'(idle), 1);
      chk("rst err", 32'(err), 0);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("rst d_valid%0d", i), 32'(h_rsp[i].d_valid), 0);
        chk($sformatf("rst a_ready%0d", i), 32'(h_rsp[i].a_ready), 0);
      end
    end else begin
      full  = (m_q.size() == MO);
      empty = (m_q.size() == 0);
      head  = empty ? 0 : m_q[0];
      any   = 1'b0;
      gnt   = m_rr;
      nv    = 1'b1;
      for (int i = 0; i < N; i++) if (h_valid[i]) nv = 1'b0;
      if (m_lock >= 0) begin
        gnt = m_lock;
        any = h_valid[gnt];
      end else begin
        for (int k = 0; k < N; k++)
          if (!any && h_valid[(m_rr + k) % N]) begin
            gnt = (m_rr + k) % N;
            any = 1'b1;
          end
      end
      chk("a_valid", 32'(d_req.a_valid), 32'(any && !full));
      if (any && !full) begin
        chk("a_address", d_req.a_address, h_addr[gnt]);
        chk("a_source", 32'(d_req.a_source), 32'(gnt));
      end
      for (int i = 0; i < N; i++) begin
        if (h_valid[i])
          chk($sformatf("a_ready%0d", i), 32'(h_rsp[i].a_ready), 32'((i == gnt) && dev_ardy && !full));
        chk($sformatf("d_valid%0d", i), 32'(h_rsp[i].d_valid), 32'(!empty && i == head && dev_dvalid));
      end
      if (!empty && dev_dvalid) chk("d_data", h_rsp[head].d_data, dev_data);
      chk("d_ready", 32'(d_req.d_ready), empty ? 32'd1 : 32'(h_dready[head]));
      chk("err_rsp", 32'(err), 32'(empty && dev_dvalid));
      chk("idle", 32'(idle), 32'(empty && nv));

      if (d_req.a_valid && dev_ardy) acc_log.push_back(int'(d_req.a_source));
      for (int i = 0; i < N; i++)
        if (h_rsp[i].d_valid && h_dready[i]) begin
          rx_host.push_back(i);
          rx_data.push_back(h_rsp[i].d_data);
        end

      if (!empty && dev_dvalid && h_dready[head]) void'(m_q.pop_front());
      if (any && !full) begin
        if (dev_ardy) begin
          m_q.push_back(gnt);
          m_rr   = (gnt + 1) % N;
          m_lock = -1;
        end else m_lock = gnt;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      h_valid[i] = (req_cnt[i] > 0);
      h_addr[i]  = {8'(i), 24'(seq[i])};
    end
  endtask

  task automatic req(input int h, input int n);
    req_cnt[h] = n;
    drive();
  endtask

  task automatic step();
    logic acc [N];
    @(negedge clk);
    for (int i = 0; i < N; i++) acc[i] = h_valid[i] && h_rsp[i].a_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        req_cnt[i]--;
        seq[i]++;
      end
    drive();
  endtask

  task automatic respond(input logic [31:0] data, input int cycles);
    dev_dvalid = 1'b1;
    dev_data   = data;
    repeat (cycles) step();
    dev_dvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      req_cnt[i]  = 0;
      seq[i]      = 0;
      h_dready[i] = 1'b1;
    end
    drive();
    dev_ardy = 1'b1; dev_dvalid = 1'b0; dev_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit reset idle", 32'(idle), 1);
    chk("lit reset a_valid", 32'(d_req.a_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // round robin over hosts 0,1,2 wraps back to 0
    req(0, 2); req(1, 1); req(2, 1);
    repeat (4) step();
    chk("lit rr n", 32'(acc_log.size()), 4);
    if (acc_log.size() == 4) begin
      chk("lit rr g0", 32'(acc_log[0]), 0);
      chk("lit rr g1", 32'(acc_log[1]), 1);
      chk("lit rr g2", 32'(acc_log[2]), 2);
      chk("lit rr g3", 32'(acc_log[3]), 0);
    end
    respond(32'h11, 4);

    // stalled device keeps host 1 granted; host 3 follows
    dev_ardy = 1'b0;
    req(1, 1);
    step();
    req(3, 1);
    step(); step();
    #1;
    chk("lit lock a_valid", 32'(d_req.a_valid), 1);
    chk("lit lock source", 32'(d_req.a_source), 1);
    chk("lit lock addr", d_req.a_address, h_addr[1]);
    dev_ardy = 1'b1;
    base = acc_log.size();
    step(); step();
    chk("lit lock n", 32'(acc_log.size() - base), 2);
    if (acc_log.size() == base + 2) begin
      chk("lit lock g0", 32'(acc_log[base]), 1);
      chk("lit lock g1", 32'(acc_log[base + 1]), 3);
    end
    respond(32'h22, 2);

    // full FIFO blocks the fifth request until a response pops
    base = acc_log.size();
    req(0, 5);
    repeat (4) step();
    chk("lit full a_valid", 32'(d_req.a_valid), 0);
    chk("lit full a_ready", 32'(h_rsp[0].a_ready), 0);
    dev_dvalid = 1'b1; dev_data = 32'h33;
    #1;
    chk("lit full pop cycle a_valid", 32'(d_req.a_valid), 0);
    step();
    dev_dvalid = 1'b0;
    #1;
    chk("lit freed a_valid", 32'(d_req.a_valid), 1);
    step();
    chk("lit full n", 32'(acc_log.size() - base), 5);
    respond(32'h44, 4);

    // responses route back in issue order
    req(2, 1); step();
    req(0, 1); step();
    req(3, 1); step();
    rx_host.delete(); rx_data.delete();
    dev_dvalid = 1'b1;
    dev_data = 32'hA; step();
    dev_data = 32'hB; step();
    dev_data = 32'hC; step();
    dev_dvalid = 1'b0;
    chk("lit route n", 32'(rx_host.size()), 3);
    if (rx_host.size() == 3) begin
      chk("lit route h0", 32'(rx_host[0]), 2); chk("lit route d0", rx_data[0], 32'hA);
      chk("lit route h1", 32'(rx_host[1]), 0); chk("lit route d1", rx_data[1], 32'hB);
      chk("lit route h2", 32'(rx_host[2]), 3); chk("lit route d2", rx_data[2], 32'hC);
    end

    // host back-pressure holds the response
    req(0, 1); step();
    rx_host.delete(); rx_data.delete();
    h_dready[0] = 1'b0;
    dev_dvalid = 1'b1; dev_data = 32'h55;
    #1;
    chk("lit bp d_ready c0", 32'(d_req.d_ready), 0);
    step();
    chk("lit bp d_ready c1", 32'(d_req.d_ready), 0);
    step();
    h_dready[0] = 1'b1;
    #1;
    chk("lit bp d_ready c2", 32'(d_req.d_ready), 1);
    step();
    dev_dvalid = 1'b0;
    chk("lit bp n", 32'(rx_host.size()), 1);
    if (rx_host.size() == 1) begin
      chk("lit bp host", 32'(rx_host[0]), 0);
      chk("lit bp data", rx_data[0], 32'h55);
    end

    // unexpected response, then reset with requests outstanding
    dev_dvalid = 1'b1; dev_data = 32'h66;
    #1;
    chk("lit unexp err", 32'(err), 1);
    chk("lit unexp d_ready", 32'(d_req.d_ready), 1);
    step();
    dev_dvalid = 1'b0;
    #1;
    chk("lit unexp err clr", 32'(err), 0);
    req(1, 1); req(2, 1);
    step(); step();
    req(3, 1);
    dev_dvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("lit arst a_valid", 32'(d_req.a_valid), 0);
    chk("lit arst idle", 32'(idle), 1);
    chk("lit arst err", 32'(err), 0);
    chk("lit arst a_ready3", 32'(h_rsp[3].a_ready), 0);
    chk("lit arst d_valid1", 32'(h_rsp[1].d_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    req(3, 0);
    dev_dvalid = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("lit post idle", 32'(idle), 1);
    dev_dvalid = 1'b1;
    #1;
    chk("lit post err", 32'(err), 1);
    chk("lit post d_valid1", 32'(h_rsp[1].d_valid), 0);
    step();
    dev_dvalid = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
